// File: rtl/handshake_ctrl_rr_arbiter_if.sv
// Handshake bundle for handshake_ctrl_rr_arbiter.
//   ins_valid   : per-requester control-token valid (requesters -> arbiter)
//   ins_ready   : per-requester ready, one-hot or zero (arbiter -> requesters)
//   index       : winning requester number, zero-extended (arbiter -> consumer)
//   index_valid : output token valid, registered (arbiter -> consumer)
//   index_ready : consumer ready (consumer -> arbiter)
// The slave modport is the arbiter's view. The master modport is the view of
// the surrounding requesters and consumer.
interface handshake_ctrl_rr_arbiter_if #(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned INDEX_WIDTH = 2
);
  logic [NUM_IN-1:0]      ins_valid;
  logic [NUM_IN-1:0]      ins_ready;
  logic [INDEX_WIDTH-1:0] index;
  logic                   index_valid;
  logic                   index_ready;

  modport slave (
    input  ins_valid,
    output ins_ready,
    output index,
    output index_valid,
    input  index_ready
  );

  modport master (
    output ins_valid,
    input  ins_ready,
    input  index,
    input  index_valid,
    output index_ready
  );
endinterface

// File: rtl/handshake_ctrl_rr_arbiter.sv
// Round-robin arbiter that lets NUM_IN control-token requesters share a single
// dataflow consumer. Each cycle it grants at most one requester and emits the
// winner's number as a token on a registered one-slot output channel. Because
// the output is registered, there is no combinational path from ins_valid to
// index_valid.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-low reset
//   bus : handshake_ctrl_rr_arbiter_if.slave (ins_valid/ins_ready in,
//         index/index_valid/index_ready out)
module handshake_ctrl_rr_arbiter #(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned INDEX_WIDTH = 2
) (
  input logic                        clk,
  input logic                        rst,
  handshake_ctrl_rr_arbiter_if.slave bus
);

  localparam int unsigned PtrW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic                   out_full_q, out_full_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic [PtrW-1:0]        ptr_q, ptr_d;

  logic [NUM_IN-1:0] grant;
  logic [PtrW-1:0]   win;
  logic              found;
  int unsigned       pos;
  logic              can_accept;
  logic              in_xfer;
  logic              out_xfer;

  // The scan starts at ptr and wraps modulo NUM_IN, so the most recent winner
  // has the lowest priority on the next transfer.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      pos = 32'(ptr_q) + k;
      if (pos >= NUM_IN) pos = pos - NUM_IN;
      if (!found && bus.ins_valid[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        win        = PtrW'(pos);
      end
    end
  end

  assign can_accept = ~out_full_q | bus.index_ready;

  // ins_ready is gated with rst because the asynchronous clear empties the
  // slot, and can_accept alone would then report a free slot during reset.
  assign bus.ins_ready   = grant & {NUM_IN{can_accept & rst}};
  assign bus.index       = index_q;
  assign bus.index_valid = out_full_q;

  assign in_xfer  = |bus.ins_ready;
  assign out_xfer = out_full_q & bus.index_ready;

  always_comb begin
    out_full_d = out_full_q;
    index_d    = index_q;
    ptr_d      = ptr_q;
    if (in_xfer) begin
      // This also covers a simultaneous dequeue: the slot stays full and takes
      // the new winner.
      out_full_d = 1'b1;
      index_d    = INDEX_WIDTH'(win);
      ptr_d      = (win == PtrW'(NUM_IN - 1)) ? '0 : win + PtrW'(1);
    end else if (out_xfer) begin
      out_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_full_q <= 1'b0;
      index_q    <= '0;
      ptr_q      <= '0;
    end else begin
      out_full_q <= out_full_d;
      index_q    <= index_d;
      ptr_q      <= ptr_d;
    end
  end

endmodule

// File: tb/tb_handshake_ctrl_rr_arbiter.sv
module tb_handshake_ctrl_rr_arbiter;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  handshake_ctrl_rr_arbiter_if #(.NUM_IN(4), .INDEX_WIDTH(2)) bus ();

  handshake_ctrl_rr_arbiter #(
    .NUM_IN     (4),
    .INDEX_WIDTH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    bus.ins_valid   = 4'b1111;
    bus.index_ready = 1'b1;

    // Reset held with every requester valid.
    tick();
    tick();
    chk("rst_ins_ready", 32'(bus.ins_ready), 32'h0);
    chk("rst_index_valid", 32'(bus.index_valid), 32'h0);
    chk("rst_index", 32'(bus.index), 32'h0);

    // Release between edges; requester 0 wins first.
    #2;
    rst = 1'b1;
    #1;
    chk("rel_ins_ready", 32'(bus.ins_ready), 32'b0001);

    // Round-robin streaming: one token per cycle, 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_index", 32'(bus.index), 32'(i % 4));
      chk("stream_valid", 32'(bus.index_valid), 32'h1);
      chk("stream_ready", 32'(bus.ins_ready), 32'(1 << ((i + 1) % 4)));
    end

    // Sparse requests, ptr back at 0: 1, 3, 1.
    bus.ins_valid = 4'b1010;
    #1;
    chk("sparse_ready0", 32'(bus.ins_ready), 32'b0010);
    tick();
    chk("sparse_index0", 32'(bus.index), 32'd1);
    chk("sparse_ready1", 32'(bus.ins_ready), 32'b1000);
    tick();
    chk("sparse_index1", 32'(bus.index), 32'd3);
    chk("sparse_ready2", 32'(bus.ins_ready), 32'b0010);
    tick();
    chk("sparse_index2", 32'(bus.index), 32'd1);

    // Only requester 0 valid with ptr at 2: scan wraps to 0.
    bus.ins_valid = 4'b0001;
    #1;
    chk("wrap_ready", 32'(bus.ins_ready), 32'b0001);
    tick();
    chk("wrap_index", 32'(bus.index), 32'd0);
    // ptr must now be 1.
    bus.ins_valid = 4'b1111;
    #1;
    chk("ptr1_ready", 32'(bus.ins_ready), 32'b0010);

    // Backpressure: fill the slot with 2 and stall.
    bus.ins_valid = 4'b0100;
    #1;
    chk("fill2_ready", 32'(bus.ins_ready), 32'b0100);
    tick();
    chk("fill2_index", 32'(bus.index), 32'd2);
    bus.index_ready = 1'b0;
    bus.ins_valid   = 4'b1000;
    #1;
    chk("bp_ready_now", 32'(bus.ins_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_index", 32'(bus.index), 32'd2);
      chk("bp_valid", 32'(bus.index_valid), 32'h1);
      chk("bp_ready", 32'(bus.ins_ready), 32'h0);
    end
    // Same edge dequeues 2 and enqueues 3.
    bus.index_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.ins_ready), 32'b1000);
    tick();
    chk("bp_swap_index", 32'(bus.index), 32'd3);
    chk("bp_swap_valid", 32'(bus.index_valid), 32'h1);

    // Idle stability: grant 2, idle 10 cycles, then all valid -> grant 3.
    bus.ins_valid = 4'b0100;
    #1;
    chk("idle_pre_ready", 32'(bus.ins_ready), 32'b0100);
    tick();
    chk("idle_pre_index", 32'(bus.index), 32'd2);
    bus.ins_valid = 4'b0000;
    tick();
    chk("idle_drain_valid", 32'(bus.index_valid), 32'h0);
    chk("idle_hold_index", 32'(bus.index), 32'd2);
    for (int i = 0; i < 9; i++) tick();
    chk("idle_still_empty", 32'(bus.index_valid), 32'h0);
    bus.ins_valid = 4'b1111;
    #1;
    chk("idle_post_ready", 32'(bus.ins_ready), 32'b1000);
    tick();
    chk("idle_post_index", 32'(bus.index), 32'd3);
    chk("idle_post_valid", 32'(bus.index_valid), 32'h1);

    // Async reset mid-stream with index 1 buffered.
    bus.ins_valid = 4'b0010;
    tick();
    chk("ar_pre_index", 32'(bus.index), 32'd1);
    chk("ar_pre_valid", 32'(bus.index_valid), 32'h1);
    bus.index_ready = 1'b0;
    bus.ins_valid   = 4'b1111;
    #1;
    rst = 1'b0;
    #1;
    chk("ar_valid_drop", 32'(bus.index_valid), 32'h0);
    chk("ar_index_clear", 32'(bus.index), 32'h0);
    chk("ar_ready_zero", 32'(bus.ins_ready), 32'h0);
    #1;
    rst             = 1'b1;
    bus.index_ready = 1'b1;
    #1;
    chk("ar_rel_ready", 32'(bus.ins_ready), 32'b0001);
    tick();
    chk("ar_first_index", 32'(bus.index), 32'd0);
    chk("ar_first_valid", 32'(bus.index_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_ctrl_rr_arbiter.md
Name: handshake_ctrl_rr_arbiter

Overview:
- Shares one dataflow consumer (e.g. a handshake_constant-fed datapath branch) between NUM_IN control-token requesters.
- Grants one requester per cycle, round-robin, and emits the winning index as a token on a registered one-slot output channel.
- Sits ahead of constant/branch units so multiple control paths can fire the same constant resource without combinational valid/ready loops.

Parameters:
- NUM_IN, 4, number of control-token input channels (1..16).
- INDEX_WIDTH, 2, width of the index output; must be at least clog2(NUM_IN), minimum 1.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset. Low means reset; deassertion is synchronised externally.
- ins_valid  input  NUM_IN  per-requester control-token valid.
- ins_ready  output  NUM_IN  per-requester ready, one-hot or zero.
- index  output  INDEX_WIDTH  winning requester number, zero-extended.
- index_valid  output  1  output token valid (registered).
- index_ready  input  1  downstream ready.

Behaviour:
- State:
  - out_full: 1 bit, drives index_valid.
  - index_q: INDEX_WIDTH bits, drives index.
  - ptr: round-robin base pointer, clog2(NUM_IN) bits, minimum 1.
- Reset (rst low, asynchronous):
  - out_full=0, index_q=0, ptr=0.
  - ins_ready forced all-zero while rst is low.
- Slot availability: can_accept = ~out_full | index_ready.
- Grant (combinational):
  - Scan ins_valid starting at position ptr, wrapping modulo NUM_IN.
  - The first asserted bit wins, giving one-hot grant.
  - grant is zero when no input is valid.
- ins_ready = grant & {NUM_IN{can_accept}}. ins_ready never depends on ins_valid of a different requester other than through the priority scan.
- Input transfer: when ins_valid[i] & ins_ready[i] for the winner w at a clock edge:
  - index_q <= w.
  - out_full <= 1.
  - ptr <= (w+1) mod NUM_IN.
- Output transfer: when index_valid & index_ready at an edge and there is no input transfer, out_full <= 0. index_q holds its value.
- Simultaneous input and output transfer: out_full stays 1 and index_q takes the new winner. Full throughput is one token per cycle.
- Latency: exactly 1 cycle from input handshake to index_valid. There is no combinational path from ins_valid to index_valid.
- Backpressure: while out_full=1 and index_ready=0:
  - ins_ready is all-zero.
  - index and index_valid hold stable (AXI-style valid persistence).
  - ptr does not move.
- ptr changes only on an input transfer. Idle cycles leave priority unchanged.
- Fairness: a continuously valid requester is granted within NUM_IN input transfers.
- NUM_IN=1: the block degenerates to a one-slot buffer with index always 0.
- Non-power-of-2 NUM_IN: ptr wraps from NUM_IN-1 to 0. The unused ptr codes are unreachable.
- Reset mid-operation:
  - A buffered token is discarded and index_valid drops asynchronously.
  - After release, priority restarts at requester 0.
- No data payload is carried. Downstream constant units attach their value to the index token.

Test Plan:
- Reset: hold rst=0 with ins_valid=4'b1111 and index_ready=1 -> ins_ready=0, index_valid=0, index=0. Release -> first grant is requester 0, and index=0 with index_valid=1 one cycle later.
- Round-robin streaming: ins_valid=4'b1111, index_ready=1 for 8 cycles -> index sequence 0,1,2,3,0,1,2,3, one token per cycle, index_valid high continuously after the first cycle.
- Sparse requests: ins_valid=4'b1010, ptr=0 -> grant 1 then 3 then 1. Then with ins_valid=4'b0001 -> grant 0 and ptr becomes 1.
- Backpressure: fill the slot with index=2, then hold index_ready=0 for 5 cycles -> index stays 2, index_valid=1, ins_ready=0. Raise index_ready with ins_valid[3]=1 -> the same edge dequeues 2 and enqueues 3.
- Idle stability: after a grant to requester 2, hold ins_valid=0 for 10 cycles, then assert 4'b1111 -> grant 3, proving ptr held at 3.
- Async reset mid-stream: pulse rst low for less than one cycle while index_valid=1 and index=1 -> index_valid falls immediately. After release, the first grant is requester 0.
